// File: rtl/matrix_operand_loader.sv
// Operand fetch stage for matrix_mult: reads two 4x4x16 matrices row by row and presents them packed.
// Define MATRIX_LOADER_TRANSPOSE_B_EN to store matrix B transposed in m2_out.
module matrix_operand_loader #(
  parameter int DIM    = 4,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_a,
  input  logic [ADDR_W-1:0]         base_b,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DIM*ELEM_W-1:0]     mem_rdata,
  input  logic                      mem_ready,
  output logic [DIM*DIM*ELEM_W-1:0] m1_out,
  output logic [DIM*DIM*ELEM_W-1:0] m2_out,
  output logic                      out_valid,
  input  logic                      out_accept,
  output logic                      busy
);

  localparam int ROW_W = DIM * ELEM_W;
  localparam int MAT_W = DIM * ROW_W;
  localparam int CNT_W = $clog2(DIM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_row;
  logic [ADDR_W-1:0]  r_baseA;
  logic [ADDR_W-1:0]  r_baseB;
  logic [MAT_W-1:0]   r_m1;
  logic [MAT_W-1:0]   r_m2;
  logic               w_lastRow;
  logic               w_capture;
  logic               w_startLoad;

  assign w_lastRow   = (r_row == CNT_W'(DIM - 1));
  assign w_capture   = mem_rd & mem_ready;
  assign w_startLoad = (r_state == IDLE) & start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The request is held combinationally from state, so a stall simply freezes row and state.
  always_comb begin
    w_nextState = r_state;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_nextState = FETCH_A;
        end
      end
      FETCH_A: begin
        mem_rd   = 1'b1;
        mem_addr = r_baseA + ADDR_W'(r_row);
        if (mem_ready && w_lastRow) begin
          w_nextState = FETCH_B;
        end
      end
      FETCH_B: begin
        mem_rd   = 1'b1;
        mem_addr = r_baseB + ADDR_W'(r_row);
        if (mem_ready && w_lastRow) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_accept) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_baseA <= '0;
      r_baseB <= '0;
    end else if (w_startLoad) begin
      r_row   <= '0;
      r_baseA <= base_a;
      r_baseB <= base_b;
    end else if (w_capture) begin
      r_row <= w_lastRow ? '0 : r_row + CNT_W'(1);
    end
  end

  // Rows overwrite the previous result in place; untouched rows keep the old load until written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m1 <= '0;
      r_m2 <= '0;
    end else if (w_capture) begin
      if (r_state == FETCH_A) begin
        r_m1[int'(r_row)*ROW_W +: ROW_W] <= mem_rdata;
      end else begin
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
        for (int c = 0; c < DIM; c++) begin
          r_m2[c*ROW_W + int'(r_row)*ELEM_W +: ELEM_W] <= mem_rdata[c*ELEM_W +: ELEM_W];
        end
`else
        r_m2[int'(r_row)*ROW_W +: ROW_W] <= mem_rdata;
`endif
      end
    end
  end

  assign m1_out = r_m1;
  assign m2_out = r_m2;

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream stage of matrix_mult; fetches two 4x4x16-bit operand matrices from row-organised operand memory.
- Issues one row read per handshake and packs the rows into the 256-bit m1/m2 format.
- Presents both matrices together with a valid/accept handshake to the multiply stage.
- Packing: element [row][col] occupies bits (row*64 + col*16)+15 : (row*64 + col*16).

Parameters:
- DIM, 4, matrix dimension (rows = cols); only 4 is supported.
- ELEM_W, 16, element width in bits.
- ADDR_W, 12, operand memory row-address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a load; sampled only in IDLE.
- base_a  in  ADDR_W  row address of row 0 of matrix A.
- base_b  in  ADDR_W  row address of row 0 of matrix B.
- mem_rd  out  1  read request, held until accepted.
- mem_addr  out  ADDR_W  row address of current request.
- mem_rdata  in  64  one matrix row; element c is at bits c*16+15:c*16.
- mem_ready  in  1  memory accepts the request and mem_rdata is valid in the same cycle.
- m1_out  out  256  packed matrix A.
- m2_out  out  256  packed matrix B.
- out_valid  out  1  m1_out/m2_out are complete and stable.
- out_accept  in  1  consumer takes the operands.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - State goes to IDLE.
  - mem_rd=0, mem_addr=0, m1_out=0, m2_out=0, out_valid=0, busy=0.
  - Row counter and latched bases are cleared.
  - Reset mid-operation abandons the load; no partial out_valid.
- States: IDLE, FETCH_A, FETCH_B, HOLD.
- IDLE:
  - start=1 latches base_a and base_b.
  - Row counter is cleared and state moves to FETCH_A.
  - start is ignored in all other states.
- FETCH_A:
  - mem_rd=1 and mem_addr = base_a + row, modulo 2^ADDR_W (wraps silently).
  - On a cycle with mem_ready=1: mem_rdata is written to m1_out[row*64+63 : row*64] and row increments.
  - On row 3 accepted: row resets to 0 and state moves to FETCH_B.
  - mem_ready=0: request, address and captured data hold unchanged; stalls of any length are allowed.
- FETCH_B:
  - Identical to FETCH_A, using base_b and writing m2_out.
  - On row 3 accepted: state moves to HOLD.
- HOLD:
  - out_valid=1 and mem_rd=0; m1_out/m2_out are stable.
  - out_accept=1 returns the state to IDLE next cycle; out_valid drops the same edge.
  - Output data is retained after accept until the next load overwrites it row by row.
- mem_rd is asserted continuously from the cycle after start through the last accepted row, with no idle gaps between rows.
- Latency with mem_ready held at 1:
  - start sampled at edge 0; rows captured at edges 1-8.
  - out_valid is high from cycle 9.
  - Each stall cycle adds one cycle.
- out_accept outside HOLD has no effect.
- start and out_accept asserted together in HOLD: return to IDLE only; start is not captured.
- base_a == base_b is legal; the same rows are read twice.
- Unsigned address arithmetic only; no data arithmetic is performed.

Optional Feature:
- Macro: MATRIX_LOADER_TRANSPOSE_B_EN.
- Defined:
  - Row r of B, element c, is written to m2_out bits (c*64 + r*16)+15 : (c*64 + r*16), so m2_out holds B transposed.
  - Lets the multiplier read columns of B as contiguous 64-bit words.
  - Fetch order and timing are unchanged.
- Undefined: B is packed exactly like A. This is the default build.

Test Plan:
- Reset, then start with base_a=0x010, base_b=0x020, mem_ready=1, memory row n = {4{n[15:0]}} -> mem_addr sequence 010,011,012,013,020,021,022,023; out_valid at cycle 9; m1_out[63:0]=0x0010001000100010; m2_out[255:192]=0x0023002300230023.
- Same load with mem_ready low for 3 cycles on row 2 of A -> mem_rd and mem_addr=0x012 held for the stall; out_valid at cycle 12; data identical to the previous test.
- base_a=0xFFE (ADDR_W=12) -> A addresses FFE, FFF, 000, 001.
- Hold out_accept=0 for 5 cycles in HOLD -> out_valid stays 1 and outputs unchanged; start pulses ignored; accept -> IDLE, busy=0 next cycle.
- Assert reset during FETCH_B row 1 -> all outputs 0 immediately (asynchronous); a new start completes a full load normally.
- With MATRIX_LOADER_TRANSPOSE_B_EN, B rows {0x0003,0x0002,0x0001,0x0000}+4r -> m2_out[r*16+15 : r*16] = r*4 (column 0 = first elements of rows); A packing unchanged.
